// File: rtl/svm_pkg.sv
// svm_pkg: shared fixed-point defaults, FSM encodings and helpers for SVM datapath blocks.
package svm_pkg;
  localparam int FEA_I_DEF = 4;
  localparam int FEA_F_DEF = 8;
  localparam logic [1:0] ST_ACC   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_OUT   = 2'd2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) r++;
    return r;
  endfunction
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
endpackage

// File: rtl/svm_adder_tree.sv
// svm_adder_tree: registered sum of LANES full-precision signed products, with a pass-through first-beat tag.
module svm_adder_tree import svm_pkg::*; #(
  parameter int W = 12,
  parameter int LANES = 4,
  localparam int SW = 2 * W + clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic [LANES*W-1:0]    a,
  input  logic [LANES*W-1:0]    b,
  output logic                  out_valid,
  output logic                  out_first,
  output logic signed [SW-1:0]  sum
);
  function automatic logic signed [2*W-1:0] mul(input logic signed [W-1:0] p, input logic signed [W-1:0] q);
    return (2 * W)'(p) * (2 * W)'(q);
  endfunction
  logic signed [SW-1:0] s;
  always_comb begin
    s = '0;
    for (int k = 0; k < LANES; k++) s = s + SW'(mul(a[k*W +: W], b[k*W +: W]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      sum <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_first <= in_first;
        sum <= s;
      end
    end
endmodule

// File: rtl/svm_mac_lane.sv
// svm_mac_lane: windowed SVM dot-product lane; accumulates WIN_LEN beats of LANES products,
// rounds to FEA_F fraction bits, adds bias and upstream partial score, and saturates.
module svm_mac_lane import svm_pkg::*; #(
  parameter int FEA_I = FEA_I_DEF,
  parameter int FEA_F = FEA_F_DEF,
  parameter int LANES = 4,
  parameter int WIN_LEN = 105,
  localparam int FEA_W = FEA_I + FEA_F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*FEA_W-1:0]   fea,
  input  logic [LANES*FEA_W-1:0]   coef,
  input  logic signed [FEA_W-1:0]  bias,
  input  logic signed [FEA_W-1:0]  chain_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [FEA_W-1:0]  out_data,
  output logic                     out_sat
);
  localparam int SW = 2 * FEA_W + clog2(LANES);
  localparam int ACC_W = 2 * FEA_W + clog2(LANES * WIN_LEN);
  localparam int CW = WIN_LEN > 1 ? clog2(WIN_LEN) : 1;
  localparam logic signed [63:0] HALF = 64'sd1 <<< (FEA_F - 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic fl;
  logic signed [FEA_W-1:0] bias_q, chain_q;
  logic signed [ACC_W-1:0] acc;
  logic take, last, first;
  logic s1_valid, s1_first;
  logic signed [SW-1:0] s1_sum;
  logic signed [63:0] pre, clamped;
  logic signed [FEA_W-1:0] res;
  logic sat;
  assign in_ready = state == ST_ACC;
  assign take = in_valid & in_ready;
  assign last = cnt == CW'(WIN_LEN - 1);
  assign first = cnt == '0;
  svm_adder_tree #(.W(FEA_W), .LANES(LANES)) u_tree (
    .clk(clk),
    .rst(rst),
    .in_valid(take),
    .in_first(first),
    .a(fea),
    .b(coef),
    .out_valid(s1_valid),
    .out_first(s1_first),
    .sum(s1_sum)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (s1_valid) acc <= s1_first ? ACC_W'(s1_sum) : acc + ACC_W'(s1_sum);
  // FLUSH spans the adder-tree and accumulator stages so acc is final when OUT is entered
  always_comb begin
    pre = ((64'(acc) + HALF) >>> FEA_F) + 64'(bias_q) + 64'(chain_q);
    clamped = saturate(pre, FEA_W);
  end
  assign res = clamped[FEA_W-1:0];
  assign sat = clamped != pre;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_ACC;
      cnt <= '0;
      fl <= 1'b0;
      bias_q <= '0;
      chain_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_sat <= 1'b0;
    end else begin
      if (take) cnt <= last ? '0 : cnt + CW'(1);
      if (take && last) begin
        bias_q <= bias;
        chain_q <= chain_in;
        fl <= 1'b0;
        state <= ST_FLUSH;
      end
      if (state == ST_FLUSH) begin
        fl <= ~fl;
        if (fl) begin
          state <= ST_OUT;
          out_valid <= 1'b1;
          out_data <= res;
          out_sat <= sat;
        end
      end
      if (state == ST_OUT && out_ready) begin
        state <= ST_ACC;
        out_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_svm_mac_lane.sv
// tb_svm_mac_lane: scenario tasks against an integer reference model of the window score.
module tb_svm_mac_lane;
  localparam int FI = 4, FF = 8, L = 2, WL = 3, W = FI + FF;
  typedef logic [L*W-1:0] beat_t;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, out_sat;
  beat_t fea = '0, coef = '0;
  logic [W-1:0] bias = '0, chain_in = '0, out_data;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  svm_mac_lane #(.FEA_I(FI), .FEA_F(FF), .LANES(L), .WIN_LEN(WL)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fea(fea),
    .coef(coef),
    .bias(bias),
    .chain_in(chain_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat)
  );
  function automatic void model(input beat_t f[WL], input beat_t c[WL], input logic [W-1:0] b, input logic [W-1:0] ch,
                                output logic [W-1:0] d, output logic s);
    longint sum, r, hi, lo;
    logic [W-1:0] x, y;
    sum = 0;
    for (int i = 0; i < WL; i++)
      for (int k = 0; k < L; k++) begin
        x = f[i][k*W +: W];
        y = c[i][k*W +: W];
        sum += longint'($signed(x)) * longint'($signed(y));
      end
    r = ((sum + (longint'(1) <<< (FF - 1))) >>> FF) + longint'($signed(b)) + longint'($signed(ch));
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    s = r > hi || r < lo;
    r = r > hi ? hi : (r < lo ? lo : r);
    d = W'(r);
  endfunction
  task automatic drive_window(input beat_t f[WL], input beat_t c[WL], input int gap,
                              output int lat, output logic [W-1:0] d, output logic s, output logic rdy);
    for (int i = 0; i < WL; i++) begin
      if (i > 0) repeat (gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      fea = f[i];
      coef = c[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rdy = in_ready;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = out_data;
    s = out_sat;
  endtask
  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic fill_const(output beat_t f[WL], output beat_t c[WL], input logic [W-1:0] fv, input logic [W-1:0] cv);
    for (int i = 0; i < WL; i++) begin
      f[i] = {L{fv}};
      c[i] = {L{cv}};
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else pass++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass++;
    total++; if (out_data !== '0) $display("FAIL reset_out_data got %0d want 0", out_data); else pass++;
    total++; if (out_sat !== 1'b0) $display("FAIL reset_out_sat got %b want 0", out_sat); else pass++;
  endtask
  task automatic test_basic();
    beat_t f[WL], c[WL];
    int lat;
    logic [W-1:0] d;
    logic s, rdy;
    bias = '0;
    chain_in = '0;
    fill_const(f, c, 12'd256, 12'd256);
    drive_window(f, c, 0, lat, d, s, rdy);
    total++; if (rdy !== 1'b0) $display("FAIL basic_flush_in_ready got %b want 0", rdy); else pass++;
    total++; if (lat !== 3) $display("FAIL basic_latency got %0d want 3", lat); else pass++;
    total++; if ($signed(d) !== 12'sd1536) $display("FAIL basic_data got %0d want 1536", $signed(d)); else pass++;
    total++; if (s !== 1'b0) $display("FAIL basic_sat got %b want 0", s); else pass++;
    handshake();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_release got valid=%b ready=%b want 0/1", out_valid, in_ready); else pass++;
  endtask
  task automatic test_saturation();
    beat_t f[WL], c[WL];
    int lat;
    logic [W-1:0] d;
    logic s, rdy;
    fill_const(f, c, 12'h7FF, 12'h7FF);
    drive_window(f, c, 0, lat, d, s, rdy);
    total++; if (d !== 12'h7FF || s !== 1'b1) $display("FAIL sat_pos got %0d/%b want 2047/1", $signed(d), s); else pass++;
    handshake();
    fill_const(f, c, 12'h800, 12'h7FF);
    drive_window(f, c, 0, lat, d, s, rdy);
    total++; if (d !== 12'h800 || s !== 1'b1) $display("FAIL sat_neg got %0d/%b want -2048/1", $signed(d), s); else pass++;
    handshake();
  endtask
  task automatic test_rounding();
    beat_t f[WL], c[WL];
    int lat;
    logic [W-1:0] d, ebias[4], echain[4], ecoef[4], edata[4];
    logic s, rdy;
    ebias = '{12'd0, 12'd0, 12'hFFB, 12'hFFB};
    echain = '{12'd0, 12'd0, 12'd10, 12'd10};
    ecoef = '{12'd128, 12'hF80, 12'd128, 12'hF80};
    edata = '{12'd1, 12'd0, 12'd6, 12'd5};
    for (int t = 0; t < 4; t++) begin
      fill_const(f, c, 12'd0, 12'd0);
      f[1] = {12'd0, 12'd1};
      c[1] = {12'd0, ecoef[t]};
      bias = ebias[t];
      chain_in = echain[t];
      drive_window(f, c, 0, lat, d, s, rdy);
      total++; if (d !== edata[t] || s !== 1'b0)
        $display("FAIL round_%0d got %0d/%b want %0d/0", t, $signed(d), s, $signed(edata[t])); else pass++;
      handshake();
    end
    bias = '0;
    chain_in = '0;
  endtask
  task automatic test_backpressure();
    beat_t f[WL], c[WL];
    int lat, bad;
    logic [W-1:0] d, ed;
    logic s, es, rdy;
    fill_const(f, c, 12'd256, 12'd256);
    drive_window(f, c, 0, lat, d, s, rdy);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      fea = beat_t'($urandom);
      coef = beat_t'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    total++; if (bad !== 0) $display("FAIL hold_stable got %0d bad cycles want 0", bad); else pass++;
    handshake();
    total++; if (in_ready !== 1'b1) $display("FAIL hold_release got in_ready=%b want 1", in_ready); else pass++;
    for (int i = 0; i < WL; i++) begin
      f[i] = beat_t'($urandom);
      c[i] = beat_t'($urandom);
    end
    model(f, c, bias, chain_in, ed, es);
    drive_window(f, c, 0, lat, d, s, rdy);
    total++; if (d !== ed || s !== es) $display("FAIL hold_next got %0d/%b want %0d/%b", $signed(d), s, $signed(ed), es); else pass++;
    handshake();
  endtask
  task automatic test_bubbles();
    beat_t f[WL], c[WL];
    int lat;
    logic [W-1:0] d;
    logic s, rdy;
    fill_const(f, c, 12'd256, 12'd256);
    drive_window(f, c, 2, lat, d, s, rdy);
    total++; if ($signed(d) !== 12'sd1536 || lat !== 3)
      $display("FAIL bubbles got %0d lat %0d want 1536 lat 3", $signed(d), lat); else pass++;
    handshake();
  endtask
  task automatic test_reset_mid();
    beat_t f[WL], c[WL];
    int lat, stale;
    logic [W-1:0] d;
    logic s, rdy;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      fea = {L{12'h7FF}};
      coef = {L{12'h7FF}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL rstmid_idle got valid=%b ready=%b want 0/1", out_valid, in_ready); else pass++;
    fill_const(f, c, 12'd256, 12'd256);
    drive_window(f, c, 0, lat, d, s, rdy);
    total++; if ($signed(d) !== 12'sd1536 || s !== 1'b0 || lat !== 3)
      $display("FAIL rstmid_data got %0d/%b lat %0d want 1536/0 lat 3", $signed(d), s, lat); else pass++;
    handshake();
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total++; if (stale !== 0) $display("FAIL rstmid_stale got %0d valid cycles want 0", stale); else pass++;
  endtask
  task automatic test_random();
    beat_t f[WL], c[WL];
    int lat;
    logic [W-1:0] d, ed;
    logic s, es, rdy;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < WL; i++) begin
        f[i] = beat_t'($urandom);
        c[i] = beat_t'($urandom);
        if (n % 3 == 0) begin
          f[i] = f[i] & {L{12'h0FF}};
          c[i] = c[i] & {L{12'h00F}};
        end
      end
      bias = W'($urandom);
      chain_in = W'($urandom);
      model(f, c, bias, chain_in, ed, es);
      drive_window(f, c, int'($urandom_range(0, 2)), lat, d, s, rdy);
      total++; if (lat !== 3) $display("FAIL rand_%0d_latency got %0d want 3", n, lat); else pass++;
      total++; if (d !== ed || s !== es)
        $display("FAIL rand_%0d_data got %0d/%b want %0d/%b", n, $signed(d), s, $signed(ed), es); else pass++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      handshake();
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/svm_mac_lane.md
SVM_MAC_LANE -- requirements
Module: svm_mac_lane

Interface
REQ-001 Parameter FEA_I, default 4, integer bits of feature/coefficient (signed, two's complement).
REQ-002 Parameter FEA_F, default 8, fractional bits; FEA_W = FEA_I+FEA_F.
REQ-003 Parameter LANES, default 4, features/coefficients consumed per input beat (>=1).
REQ-004 Parameter WIN_LEN, default 105, input beats per detection window (>=1).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 in_valid  in  1  input beat valid.
REQ-008 in_ready  out  1  block accepts beat; beat transfers when in_valid&in_ready.
REQ-009 fea  in  LANES*FEA_W  packed signed features, lane k at [k*FEA_W +: FEA_W].
REQ-010 coef  in  LANES*FEA_W  packed signed SVM coefficients, same packing.
REQ-011 bias  in  FEA_W  signed bias, quasi-static, sampled with the last beat of a window.
REQ-012 chain_in  in  FEA_W  signed partial score from upstream PE, sampled with the last beat.
REQ-013 out_valid  out  1  window score valid.
REQ-014 out_ready  in  1  downstream accepts score.
REQ-015 out_data  out  FEA_W  signed window score, FEA_F fractional bits.
REQ-016 out_sat  out  1  score was clamped; valid with out_valid.

Function
REQ-017 States: ACC (in_ready=1), FLUSH (2 cycles, in_ready=0), OUT (out_valid=1, in_ready=0).
REQ-018 ACC: each accepted beat increments beat counter; beat counter WIN_LEN-1 accepted -> counter to 0, latch bias/chain_in, go FLUSH.
REQ-019 Stage 1: cycle after acceptance, registered sum of LANES full-precision products (2*FEA_W+clog2(LANES) bits).
REQ-020 Stage 2: accumulator ACC_W = 2*FEA_W+clog2(LANES*WIN_LEN) bits; first product sum of a window loads, later ones add; no internal overflow possible.
REQ-021 Result: (acc + 2^(FEA_F-1)) arithmetic-shift-right FEA_F, plus sign-extended bias and chain_in, clamped to [-2^(FEA_W-1), 2^(FEA_W-1)-1]; out_sat=1 iff clamped.
REQ-022 Latency: last beat accepted in cycle T -> out_valid=1 in cycle T+3.
REQ-023 OUT: out_data/out_sat held stable until out_valid&out_ready; then out_valid=0 and ACC with in_ready=1 next cycle.
REQ-024 Gaps in in_valid during ACC stall counter and accumulation only; result unaffected.
REQ-025 Beats offered while in_ready=0 are not consumed and do not alter state.
REQ-026 WIN_LEN=1: every accepted beat is a full window.

Reset
REQ-027 rst asserted: state ACC, beat counter 0, pipeline valids 0, accumulator 0, out_valid 0, out_data 0, out_sat 0, in_ready 1 after release.
REQ-028 rst mid-window or during OUT discards partial window/pending score; next accepted beat starts a new window.

Structure
REQ-029 Shared package svm_pkg holds FEA_I/FEA_F defaults, clog2 function and signed saturate function; reused by other SVM blocks.
REQ-030 One sub-module svm_adder_tree (registered LANES-input signed product sum) forms stage 1; control FSM, accumulator and output stage live in svm_mac_lane.

Verification (FEA_I=4, FEA_F=8, LANES=2, WIN_LEN=3)
REQ-031 All fea=256, coef=256, bias=0, chain_in=0, 3 back-to-back beats -> out_data=1536, out_sat=0, out_valid 3 cycles after last beat.
REQ-032 fea=2047, coef=2047 all lanes -> out_data=2047, out_sat=1; fea=-2048, coef=2047 -> out_data=-2048, out_sat=1.
REQ-033 Rounding: single nonzero product 128 -> out_data=1; single product -128 -> out_data=0; with bias=-5, chain_in=10 added -> 6 and 5.
REQ-034 out_ready low 5 cycles after out_valid -> out_data stable, in_ready=0, offered beats ignored; out_ready high -> handshake, in_ready=1 next cycle, next window correct.
REQ-035 Scenario REQ-031 with 2-cycle in_valid bubbles between beats -> out_data=1536.
REQ-036 rst pulse after 2 beats, then full REQ-031 window -> single result 1536, no stale output.
